// File: rtl/fnd_apb_scheduler_if.sv
// APB bus between the FND update scheduler (master) and the FND count peripheral (slave).
interface fnd_apb_scheduler_if;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic        PREADY;

  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PREADY);
  modport slave  (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PREADY);
endinterface

// File: rtl/fnd_apb_scheduler.sv
// APB master sharing the FND peripheral between two requesters (FCR enable, then FDR/FPR per grant).
// Optional PREADY timeout with sticky err: define FND_SCHED_TIMEOUT_EN.
module fnd_apb_scheduler #(
  parameter logic [3:0] FCR_ADDR       = 4'h0,
  parameter logic [3:0] FDR_ADDR       = 4'h4,
  parameter logic [3:0] FPR_ADDR       = 4'h8,
  parameter int         MAX_VAL        = 9999,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [1:0]                req,
  input  logic [13:0]               req_val0,
  input  logic [13:0]               req_val1,
  input  logic [3:0]                req_dp0,
  input  logic [3:0]                req_dp1,
  output logic [1:0]                ack,
  output logic                      busy,
  output logic                      err,
  fnd_apb_scheduler_if.master       apb
);

  typedef enum logic [1:0] {INIT_SETUP, IDLE, SETUP, ACCESS} state_t;

  localparam logic [13:0] MAX_LIM = 14'(MAX_VAL);

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        last_q, last_d;
  logic        grant_q, grant_d;
  logic [13:0] val_q, val_d;
  logic [3:0]  dp_q, dp_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q;
  logic [3:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [1:0]  ack_q, ack_d;
  logic        timeout;

  function automatic logic [13:0] sat(input logic [13:0] v);
    return (v > MAX_LIM) ? MAX_LIM : v;
  endfunction

`ifdef FND_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] to_cnt_q;
  logic          err_q;

  assign timeout = (state_q == ACCESS) && !apb.PREADY && (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == ACCESS) ? to_cnt_q + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Bus outputs are registered from the next-state decision so reset leaves the bus quiet.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    last_d    = last_q;
    grant_d   = grant_q;
    val_d     = val_q;
    dp_d      = dp_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    ack_d     = 2'b00;
    case (state_q)
      INIT_SETUP: begin
        state_d   = SETUP;
        step_d    = 2'd0;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        paddr_d   = FCR_ADDR;
        pwdata_d  = 32'd1;
      end
      IDLE: begin
        // The ack cycle never arbitrates, so a still-held request waits one more cycle.
        if (req != 2'b00 && ack_q == 2'b00) begin
          grant_d   = req[1] & (~req[0] | ~last_q);
          last_d    = grant_d;
          val_d     = grant_d ? sat(req_val1) : sat(req_val0);
          dp_d      = grant_d ? req_dp1 : req_dp0;
          state_d   = SETUP;
          step_d    = 2'd1;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = FDR_ADDR;
          pwdata_d  = {18'b0, val_d};
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (apb.PREADY && step_q == 2'd1) begin
          state_d   = SETUP;
          step_d    = 2'd2;
          penable_d = 1'b0;
          paddr_d   = FPR_ADDR;
          pwdata_d  = {28'b0, dp_q};
        end else if (apb.PREADY || timeout) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (step_q != 2'd0) ack_d = grant_q ? 2'b10 : 2'b01;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= INIT_SETUP;
      step_q    <= 2'd0;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      val_q     <= '0;
      dp_q      <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      val_q     <= val_d;
      dp_q      <= dp_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= psel_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ack_q     <= ack_d;
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign ack         = ack_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fnd_apb_scheduler.sv
// Scoreboard bench for fnd_apb_scheduler: random requests against a round-robin reference model.
module tb_fnd_apb_scheduler;

  localparam logic [3:0] FCR = 4'h0;
  localparam logic [3:0] FDR = 4'h4;
  localparam logic [3:0] FPR = 4'h8;

  typedef struct {logic [3:0] addr; logic [31:0] data;} wr_t;
  typedef struct {int n; bit timed;} ack_t;

  logic        PCLK, PRESET;
  logic [1:0]  req, ack;
  logic [13:0] req_val0, req_val1;
  logic [3:0]  req_dp0, req_dp1;
  logic        busy, err;

  fnd_apb_scheduler_if bus ();

  fnd_apb_scheduler dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req),
    .req_val0(req_val0), .req_val1(req_val1),
    .req_dp0(req_dp0), .req_dp1(req_dp1),
    .ack(ack), .busy(busy), .err(err), .apb(bus)
  );

  wr_t         exp_wr[$];
  ack_t        exp_ack[$];
  int          n_checks = 0, n_fail = 0;
  int          cycle = 0, fpr_cycle = -10;
  int          delay_lo = 1, delay_hi = 1, wcnt = 0, delay = 1;
  bit          stall = 0, b2b_pending = 0, model_last = 1;
  logic [3:0]  setup_addr;
  logic [31:0] setup_data, ctrl_reg = 0;

  initial begin
    PCLK = 0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  function automatic logic [31:0] satModel(input int v);
    return (v > 9999) ? 32'd9999 : 32'(v);
  endfunction

  // Slave: PREADY after a random number of ACCESS cycles, or never while stalled.
  initial begin
    bus.PREADY = 0;
    forever begin
      @(posedge PCLK);
      #1;
      if (bus.PSEL && bus.PENABLE && !stall) begin
        bus.PREADY = (wcnt >= delay);
        wcnt++;
      end else begin
        bus.PREADY = 0;
        wcnt = 0;
        delay = $urandom_range(delay_hi, delay_lo);
      end
    end
  end

  always @(negedge PCLK) begin
    wr_t  w;
    ack_t a;
    if (PRESET) begin
      b2b_pending = 0;
    end else begin
      if (b2b_pending) begin
        checkOutput("fpr_back_to_back", 32'({bus.PSEL, bus.PENABLE, bus.PADDR}), 32'({1'b1, 1'b0, FPR}));
        b2b_pending = 0;
      end
      if (bus.PSEL && !bus.PENABLE) begin
        setup_addr = bus.PADDR;
        setup_data = bus.PWDATA;
      end else if (bus.PSEL && bus.PENABLE) begin
        checkOutput("access_paddr_stable", 32'(bus.PADDR), 32'(setup_addr));
        checkOutput("access_pwdata_stable", bus.PWDATA, setup_data);
        checkOutput("pwrite_high", 32'(bus.PWRITE), 32'd1);
        if (bus.PREADY) begin
          if (exp_wr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_write: got addr %0h data %0h, required none", bus.PADDR, bus.PWDATA);
          end else begin
            w = exp_wr.pop_front();
            checkOutput("write_addr", 32'(bus.PADDR), 32'(w.addr));
            checkOutput("write_data", bus.PWDATA, w.data);
          end
          if (bus.PADDR == FCR) ctrl_reg = bus.PWDATA;
          if (bus.PADDR == FDR) b2b_pending = 1;
          if (bus.PADDR == FPR) fpr_cycle = cycle;
        end
      end
      if (ack != 2'b00) begin
        if (exp_ack.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_ack: got %b, required 00", ack);
        end else begin
          a = exp_ack.pop_front();
          checkOutput("ack_owner", 32'(ack), 32'(1 << a.n));
          if (a.timed) checkOutput("ack_latency", 32'(cycle - fpr_cycle), 32'd1);
        end
      end
    end
  end

  // Pushes the model's grant sequence, holds req until the expected acks arrive, drops it in the last ack cycle.
  task automatic applyStimulus(input logic [1:0] mask, input int grants, input bit with_writes);
    int n, got;
    for (int g = 0; g < grants; g++) begin
      if (mask == 2'b01)      n = 0;
      else if (mask == 2'b10) n = 1;
      else                    n = model_last ? 0 : 1;
      model_last = n[0];
      if (with_writes) begin
        exp_wr.push_back('{FDR, satModel(n == 0 ? int'(req_val0) : int'(req_val1))});
        exp_wr.push_back('{FPR, {28'b0, (n == 0 ? req_dp0 : req_dp1)}});
      end
      exp_ack.push_back('{n, with_writes});
    end
    req = mask;
    got = 0;
    for (int c = 0; c < 200 * grants && got < grants; c++) begin
      @(posedge PCLK);
      #1;
      if (ack != 2'b00) begin
        got++;
        if (got == grants) req = 2'b00;
      end
    end
    req = 2'b00;
    if (got < grants) checkOutput("ack_wait_timeout", 32'(got), 32'(grants));
  endtask

  task automatic waitIdle(input int limit);
    bit done = 0;
    for (int c = 0; c < limit && !done; c++) begin
      @(posedge PCLK);
      #2;
      done = !busy && exp_wr.size() == 0 && exp_ack.size() == 0;
    end
    if (!done) checkOutput("idle_wait_timeout", 32'(busy), 32'd0);
  endtask

  task automatic finishTest();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  initial begin
    repeat (60000) @(posedge PCLK);
    n_fail++;
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    finishTest();
  end

  initial begin
    PRESET = 1;
    req = 0;
    req_val0 = 0; req_val1 = 0; req_dp0 = 0; req_dp1 = 0;
    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("reset_psel", 32'(bus.PSEL), 0);
    checkOutput("reset_penable", 32'(bus.PENABLE), 0);
    checkOutput("reset_ack", 32'(ack), 0);
    checkOutput("reset_busy", 32'(busy), 1);
    checkOutput("reset_err", 32'(err), 0);
    exp_wr.push_back('{FCR, 32'd1});
    @(negedge PCLK);
    #1 PRESET = 0;
    waitIdle(100);
    checkOutput("init_busy", 32'(busy), 0);
    checkOutput("init_psel", 32'(bus.PSEL), 0);
    checkOutput("init_ctrl_reg", ctrl_reg, 1);

    req_val0 = 14'd1234; req_dp0 = 4'b1011;
    applyStimulus(2'b01, 1, 1);
    waitIdle(50);

    req_val0 = 14'd42; req_dp0 = 4'h1; req_val1 = 14'd777; req_dp1 = 4'h8;
    applyStimulus(2'b11, 4, 1);
    waitIdle(50);

    req_val1 = 14'd16000; req_dp1 = 4'h3;
    applyStimulus(2'b10, 1, 1);

    delay_lo = 5; delay_hi = 5;
    req_val0 = 14'd8888; req_dp0 = 4'h6;
    applyStimulus(2'b01, 1, 1);
    waitIdle(50);

    for (int i = 0; i < 12; i++) begin
      delay_lo = 1;
      delay_hi = $urandom_range(5, 1);
      req_val0 = 14'($urandom_range(16383, 0));
      req_val1 = 14'($urandom_range(16383, 0));
      req_dp0 = 4'($urandom);
      req_dp1 = 4'($urandom);
      applyStimulus(2'($urandom_range(3, 1)), $urandom_range(3, 1), 1);
      waitIdle(50);
    end

    delay_lo = 3; delay_hi = 3;
    req_val0 = 14'd555; req_dp0 = 4'h2;
    exp_wr.push_back('{FDR, 32'd555});
    exp_wr.push_back('{FPR, 32'h2});
    req = 2'b01;
    begin
      bit seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge PCLK);
        seen = bus.PSEL && bus.PENABLE && bus.PADDR == FPR;
      end
      checkOutput("reached_fpr_access", 32'(seen), 1);
    end
    #2 PRESET = 1;
    #1;
    checkOutput("abort_psel", 32'(bus.PSEL), 0);
    checkOutput("abort_penable", 32'(bus.PENABLE), 0);
    checkOutput("abort_ack", 32'(ack), 0);
    checkOutput("abort_busy", 32'(busy), 1);
    exp_wr.delete();
    exp_ack.delete();
    req = 0;
    model_last = 1;
    ctrl_reg = 0;
    exp_wr.push_back('{FCR, 32'd1});
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    #1 PRESET = 0;
    waitIdle(100);
    checkOutput("reinit_ctrl_reg", ctrl_reg, 1);

    delay_lo = 1; delay_hi = 1;
    req_val0 = 14'd10; req_dp0 = 4'h4; req_val1 = 14'd20; req_dp1 = 4'h5;
    applyStimulus(2'b11, 2, 1);
    waitIdle(50);

`ifdef FND_SCHED_TIMEOUT_EN
    stall = 1;
    req_val0 = 14'd99; req_dp0 = 4'h9;
    applyStimulus(2'b01, 1, 0);
    #2;
    checkOutput("timeout_err", 32'(err), 1);
    checkOutput("timeout_psel", 32'(bus.PSEL), 0);
    stall = 0;
    waitIdle(50);
`else
    checkOutput("err_tied_low", 32'(err), 0);
`endif

    repeat (5) @(posedge PCLK);
    checkOutput("pending_writes", 32'(exp_wr.size()), 0);
    checkOutput("pending_acks", 32'(exp_ack.size()), 0);
    finishTest();
  end

endmodule
